// File: rtl/sobel_edge_ctrl.sv
// Streaming 3x3 Sobel edge detector, one 8-bit pixel in per pi_flag, one edge pixel out per interior window.
// Latency: po_flag rises exactly 3 clk edges after the edge sampling the window's bottom-right pixel.
// Backpressure: none; pipeline free-runs every clk, input gaps simply propagate as po_flag=0 cycles.
// Optional build macro SOBEL_GRAY_OUT_EN: output saturated gradient magnitude instead of binary threshold.
module sobel_edge_ctrl #(
  parameter int          COLS      = 200,
  parameter int          ROWS      = 200,
  parameter logic [10:0] THRESHOLD = 11'd100,
  parameter logic [7:0]  EDGE_VAL  = 8'hFF,
  parameter logic [7:0]  BG_VAL    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pi_flag,
  input  logic [7:0] pi_data,
  output logic       po_flag,
  output logic [7:0] po_rgb,
  output logic       po_eof
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;

  // Line buffers: lb1 holds the previous row, lb2 the row before that.
  logic [7:0] lb1 [COLS];
  logic [7:0] lb2 [COLS];
  logic [7:0] lb1_rd, lb2_rd;

  // Window w_q[row][col], row 0 is the oldest row, col 2 the newest column.
  logic [7:0] w_q [3][3];
  logic       v0_q, eof0_q;

  logic signed [10:0] gx_q, gy_q, gx_d, gy_d;
  logic               v1_q, eof1_q;
  logic        [10:0] mag_q, mag_d;
  logic               v2_q, eof2_q;

  logic [10:0] px_pos, px_neg, py_pos, py_neg;
  logic [10:0] abs_x, abs_y;

  assign lb1_rd = lb1[col_cnt_q];
  assign lb2_rd = lb2[col_cnt_q];

  // Next raster position: column wraps at the row end, row wraps at the frame end.
  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (pi_flag) begin
      if (col_cnt_q == COL_LAST) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end
    end
  end

  // Line buffer update: the column slot rolls down one row and takes the new pixel; no reset needed.
  always_ff @(posedge clk) begin
    if (pi_flag) begin
      lb2[col_cnt_q] <= lb1_rd;
      lb1[col_cnt_q] <= pi_data;
    end
  end

  // Raster counters, window shift and the window-valid / end-of-frame tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      v0_q      <= 1'b0;
      eof0_q    <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w_q[r][c] <= '0;
    end else begin
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      // Windows touching the first two rows or columns are not interior and produce no output.
      v0_q   <= pi_flag && (row_cnt_q >= RW'(2)) && (col_cnt_q >= CW'(2));
      eof0_q <= pi_flag && (row_cnt_q >= RW'(2)) && (col_cnt_q >= CW'(2))
                && (row_cnt_q == ROW_LAST) && (col_cnt_q == COL_LAST);
      if (pi_flag) begin
        for (int r = 0; r < 3; r++) begin
          w_q[r][0] <= w_q[r][1];
          w_q[r][1] <= w_q[r][2];
        end
        w_q[0][2] <= lb2_rd;
        w_q[1][2] <= lb1_rd;
        w_q[2][2] <= pi_data;
      end
    end
  end

  // Sobel kernels as sums of non-negative terms; each sum is at most 1020 so 11 bits never overflow.
  always_comb begin
    px_pos = {3'b0, w_q[0][2]} + {2'b0, w_q[1][2], 1'b0} + {3'b0, w_q[2][2]};
    px_neg = {3'b0, w_q[0][0]} + {2'b0, w_q[1][0], 1'b0} + {3'b0, w_q[2][0]};
    py_pos = {3'b0, w_q[2][0]} + {2'b0, w_q[2][1], 1'b0} + {3'b0, w_q[2][2]};
    py_neg = {3'b0, w_q[0][0]} + {2'b0, w_q[0][1], 1'b0} + {3'b0, w_q[0][2]};
    gx_d   = signed'(px_pos - px_neg);
    gy_d   = signed'(py_pos - py_neg);
  end

  // Magnitude: |gx|+|gy| peaks at 2040, still inside 11 unsigned bits.
  always_comb begin
    abs_x = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
    abs_y = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
    mag_d = abs_x + abs_y;
  end

  // Three pipeline stages: gradients, magnitude, output decision; valid tags travel alongside.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gx_q    <= '0;
      gy_q    <= '0;
      v1_q    <= 1'b0;
      eof1_q  <= 1'b0;
      mag_q   <= '0;
      v2_q    <= 1'b0;
      eof2_q  <= 1'b0;
      po_flag <= 1'b0;
      po_eof  <= 1'b0;
      po_rgb  <= BG_VAL;
    end else begin
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      v1_q    <= v0_q;
      eof1_q  <= eof0_q;
      mag_q   <= mag_d;
      v2_q    <= v1_q;
      eof2_q  <= eof1_q;
      po_flag <= v2_q;
      po_eof  <= eof2_q;
      // po_rgb only changes on a valid beat so the display side sees a stable value between pulses.
      if (v2_q) begin
`ifdef SOBEL_GRAY_OUT_EN
        po_rgb <= (mag_q > 11'd255) ? 8'hFF : mag_q[7:0];
`else
        po_rgb <= (mag_q >= THRESHOLD) ? EDGE_VAL : BG_VAL;
`endif
      end
    end
  end

endmodule
